// File: rtl/multi_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_debouncer_if
// Brief    : Raw switch inputs and conditioned level/tick outputs for
//            multi_debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sw_i;
    logic [N_CH-1:0] db_level_o;
    logic [N_CH-1:0] rise_tick_o;
    logic [N_CH-1:0] fall_tick_o;
    logic [N_CH-1:0] hold_tick_o;

    modport master (
        output sw_i,
        input  db_level_o,
        input  rise_tick_o,
        input  fall_tick_o,
        input  hold_tick_o
    );

    modport slave (
        input  sw_i,
        output db_level_o,
        output rise_tick_o,
        output fall_tick_o,
        output hold_tick_o
    );
endinterface
`default_nettype wire

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : multi_debouncer
// Brief    : N independent channels of 2-FF sync, mismatch-count debounce,
//            rise/fall ticks and long-press tick with optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multi_debouncer_if.slave bus
);
    localparam int c_MAX_DH  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int c_MAX_ALL = (c_MAX_DH > REPEAT_CYCLES) ? c_MAX_DH : REPEAT_CYCLES;
    localparam int CNT_W     = $clog2(c_MAX_ALL + 1);

    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD      = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_hold;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic             r_hold;
        logic [CNT_W-1:0] r_dc;
        logic [CNT_W-1:0] r_hc;
        logic             w_flip;
        logic             w_fall_now;
        logic             w_hold_hit;
        logic             w_rep_hit;

        // The DB_CYCLES-th consecutive disagreeing sample commits the new level
        assign w_flip     = (r_sync2 != r_level) && (r_dc == c_DB_LAST);
        assign w_fall_now = w_flip && r_level;
        // A release on the same edge overrides any hold/repeat match
        assign w_hold_hit = r_level && !w_fall_now && (r_hc == c_HOLD_LAST);

        if (REPEAT_CYCLES > 0) begin : g_rep
            localparam logic [CNT_W-1:0] c_REP = CNT_W'(REPEAT_CYCLES);
            logic [CNT_W-1:0] r_rc;
            logic [CNT_W-1:0] w_rc_next;

            assign w_rc_next = (r_rc == c_REP) ? c_ONE : r_rc + c_ONE;
            assign w_rep_hit = r_level && !w_fall_now && (r_hc == c_HOLD)
                               && (w_rc_next == c_REP);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_rc <= '0;
                end else if (!r_level || w_fall_now) begin
                    r_rc <= '0;
                end else if (r_hc == c_HOLD) begin
                    r_rc <= w_rc_next;
                end
            end
        end else begin : g_no_rep
            assign w_rep_hit = 1'b0;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_hold  <= 1'b0;
                r_dc    <= '0;
                r_hc    <= '0;
            end else begin
                r_sync1 <= bus.sw_i[i];
                r_sync2 <= r_sync1;
                r_rise  <= w_flip && !r_level;
                r_fall  <= w_fall_now;
                r_hold  <= w_hold_hit || w_rep_hit;

                if ((r_sync2 == r_level) || w_flip) begin
                    r_dc <= '0;
                end else begin
                    r_dc <= r_dc + c_ONE;
                end

                if (w_flip) begin
                    r_level <= r_sync2;
                end

                // Hold count only runs while the committed level is high
                if (!r_level || w_fall_now) begin
                    r_hc <= '0;
                end else if (r_hc != c_HOLD) begin
                    r_hc <= r_hc + c_ONE;
                end
            end
        end

        assign w_level[i] = r_level;
        assign w_rise[i]  = r_rise;
        assign w_fall[i]  = r_fall;
        assign w_hold[i]  = r_hold;
    end

    assign bus.db_level_o  = w_level;
    assign bus.rise_tick_o = w_rise;
    assign bus.fall_tick_o = w_fall;
    assign bus.hold_tick_o = w_hold;
endmodule
`default_nettype wire

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel switch/button conditioner for the board-level input path, sitting between raw pins and user logic such as the UART echo and control FSMs. Each channel gets:
- a 2-FF synchroniser;
- mismatch-counting debounce against its stable level;
- registered rise and fall ticks;
- a long-press (hold) tick with optional auto-repeat.

All channels are independent and share only clock and reset.

Parameters:
N_CH, 4, number of independent input channels (>=1)
DB_CYCLES, 1_000_000, consecutive mismatching samples needed to accept a level change (>=2; 20 ms at 50 MHz)
HOLD_CYCLES, 50_000_000, cycles the stable level must stay high before hold_tick (>=1)
REPEAT_CYCLES, 0, auto-repeat period after the hold tick; 0 disables repeat
CNT_W, derived, $clog2(max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1); localparam, not overridable

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
sw_i  input  N_CH  raw asynchronous switch inputs, active-high
db_level_o  output  N_CH  debounced stable level per channel
rise_tick_o  output  N_CH  one-cycle pulse when stable level goes 0->1
fall_tick_o  output  N_CH  one-cycle pulse when stable level goes 1->0
hold_tick_o  output  N_CH  one-cycle pulse on long press, then on each repeat

Behaviour:
- Reset (async, immediate): sync FFs = 0; stable level L = 0; all counters = 0; all outputs = 0. No ticks are generated by reset assertion or release.
- Synchroniser: s[i] = sw_i[i] delayed 2 clk_i edges.
- Debounce counter dc[i], per channel, evaluated each edge:
  - s==L: dc <= 0.
  - s!=L and dc < DB_CYCLES-1: dc <= dc+1.
  - s!=L and dc == DB_CYCLES-1: L <= s, dc <= 0.
- Latency: if sw_i changes before edge k and stays stable, L changes at edge k+1+DB_CYCLES. Any sample with s==L before then restarts the count from 0.
- db_level_o = L, registered.
- rise_tick_o / fall_tick_o: registered, high for exactly the cycle after the edge at which L changes. They are coincident with the first cycle of the new db_level_o value. They are never both high on one channel.
- Hold counter hc[i]:
  - Cleared while L==0 or on the edge L rises.
  - Increments each edge while L==1; saturates at HOLD_CYCLES.
  - s bouncing while L==1 does not affect hc.
- hold_tick_o:
  - Pulses one cycle when hc reaches HOLD_CYCLES, i.e. after edge A+HOLD_CYCLES, where A is the edge at which L rose.
- Repeat (REPEAT_CYCLES>0):
  - After the hold tick, repeat counter rc counts 1..REPEAT_CYCLES and wraps.
  - hold_tick_o pulses at A+HOLD_CYCLES+n*REPEAT_CYCLES, n>=1, while L==1.
  - rc clears when L falls.
- Release during hold: the edge at which L falls clears hc and rc. No hold tick is issued at or after that edge, even if the count would have matched on it.
- Simultaneous events on different channels are fully independent; several bits may tick in the same cycle.
- Counter arithmetic is unsigned CNT_W-bit with no wrap beyond the stated limits.

Test Plan:
All scenarios use N_CH=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.

1. Clean press: sw_i[0] 0->1 before edge k, held high -> db_level_o[0]=1 and rise_tick_o[0]=1 after edge k+5, with rise tick one cycle wide; channel 1 stays 0 throughout.
2. Bounce rejection: sw_i[0] pattern of 3 cycles high, 1 low, repeated 10 times -> db_level_o[0] stays 0; no ticks.
3. Threshold: 3-cycle high glitch -> ignored. 4-cycle high pulse -> accepted; db_level_o returns to 0 with fall_tick_o 4 edges after the synchronised fall.
4. Long press and repeat: sw_i[0] held high with L rising at edge A -> hold_tick_o[0] after edges A+10, A+13, A+16. On release, fall_tick_o[0] pulses once and hold ticks stop.
5. Channel independence: sw_i=2'b11 applied at the same edge -> both rise ticks in the same cycle. sw_i[1] released alone -> only fall_tick_o[1].
6. Reset mid-operation: assert rst_i while dc[0]=3 and L[1]=1 -> all outputs 0 immediately, without waiting for an edge. After release with sw_i=2'b11 held -> rise ticks on both channels after the full 2+4-edge latency, and no fall tick is ever produced.
